// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - raster timing parameter sets and shared helpers
package video_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  localparam timing_t TIMING_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam timing_t TIMING_800X600 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam timing_t TIMING_1280X720 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  // Blue-channel control word layout seen by the TMDS encoder.
  localparam int CTRL_VSYNC_BIT = 1;
  localparam int CTRL_HSYNC_BIT = 0;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [1:0] pack_ctrl(input logic vs, input logic hs);
    logic [1:0] c;
    c = '0;
    c[CTRL_VSYNC_BIT] = vs;
    c[CTRL_HSYNC_BIT] = hs;
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// rtl/video_timing_gen_axis_counter.sv - wrapping axis counter with active/sync window decode
module timing_axis_counter #(
  parameter int CW         = 12,
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_step,
  output logic [CW-1:0] o_pos,
  output logic          o_active,
  output logic          o_sync
);

  localparam logic [CW-1:0] L_LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] L_ACTIVE     = CW'(ACTIVE);
  localparam logic [CW-1:0] L_SYNC_START = CW'(SYNC_START);
  localparam logic [CW-1:0] L_SYNC_END   = CW'(SYNC_END);

  logic [CW-1:0] r_pos;

  // >= rather than == so the count can never escape the legal range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
    end else if (i_step) begin
      r_pos <= (r_pos >= L_LAST) ? '0 : r_pos + CW'(1);
    end
  end

  assign o_pos    = r_pos;
  assign o_active = (r_pos < L_ACTIVE);
  assign o_sync   = (r_pos >= L_SYNC_START) && (r_pos < L_SYNC_END);

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator feeding the TMDS channel encoders
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = TIMING_640X480.h_active,
  parameter int H_FP     = TIMING_640X480.h_fp,
  parameter int H_SYNC   = TIMING_640X480.h_sync,
  parameter int H_BP     = TIMING_640X480.h_bp,
  parameter int V_ACTIVE = TIMING_640X480.v_active,
  parameter int V_FP     = TIMING_640X480.v_fp,
  parameter int V_SYNC   = TIMING_640X480.v_sync,
  parameter int V_BP     = TIMING_640X480.v_bp,
  parameter bit HS_POL   = TIMING_640X480.hs_pol,
  parameter bit VS_POL   = TIMING_640X480.vs_pol,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [1:0]    ctrl,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);

  logic [CW-1:0] w_hc;
  logic [CW-1:0] w_vc;
  logic          w_h_active;
  logic          w_h_sync;
  logic          w_v_active;
  logic          w_v_sync;
  logic          w_v_step;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_de;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_line_start;
  logic          r_frame_start;

  assign w_v_step = ce & (w_hc == H_LAST);

  timing_axis_counter #(
    .CW         (CW),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_step   (ce),
    .o_pos    (w_hc),
    .o_active (w_h_active),
    .o_sync   (w_h_sync)
  );

  // Vertical axis advances only on the horizontal wrap, so vsync edges land on hc==0.
  timing_axis_counter #(
    .CW         (CW),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_step   (w_v_step),
    .o_pos    (w_vc),
    .o_active (w_v_active),
    .o_sync   (w_v_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_x           <= w_hc;
      r_y           <= w_vc;
      r_de          <= w_h_active & w_v_active;
      r_hsync       <= w_h_sync ? HS_POL : ~HS_POL;
      r_vsync       <= w_v_sync ? VS_POL : ~VS_POL;
      r_line_start  <= (w_hc == '0);
      r_frame_start <= (w_hc == '0) && (w_vc == '0);
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign ctrl        = pack_ctrl(r_vsync, r_hsync);
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench: default 640x480 instance plus a small-raster instance
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_n_a = 1'b1;
  logic        ce_a    = 1'b0;
  logic [11:0] x_a, y_a;
  logic        de_a, hs_a, vs_a, ls_a, fs_a;
  logic [1:0]  ctrl_a;

  logic        rst_n_s = 1'b1;
  logic        ce_s    = 1'b0;
  logic [7:0]  x_s, y_s;
  logic        de_s, hs_s, vs_s, ls_s, fs_s;
  logic [1:0]  ctrl_s;

  video_timing_gen u_dflt (
    .clk(clk), .rst_n(rst_n_a), .ce(ce_a), .x(x_a), .y(y_a), .de(de_a),
    .hsync(hs_a), .vsync(vs_a), .ctrl(ctrl_a), .line_start(ls_a), .frame_start(fs_a)
  );

  // Small raster: H 16/2/3/4 (total 25, hsync x=18..20), V 6/1/2/2 (total 11, vsync y=7..8).
  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .CW(8)
  ) u_small (
    .clk(clk), .rst_n(rst_n_s), .ce(ce_s), .x(x_s), .y(y_s), .de(de_s),
    .hsync(hs_s), .vsync(vs_s), .ctrl(ctrl_s), .line_start(ls_s), .frame_start(fs_s)
  );

  localparam logic [30:0] RST_A = {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
  localparam logic [22:0] RST_S = {8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] got_a();
    return {x_a, y_a, de_a, hs_a, vs_a, ctrl_a, ls_a, fs_a};
  endfunction

  function automatic logic [22:0] got_s();
    return {x_s, y_s, de_s, hs_s, vs_s, ctrl_s, ls_s, fs_s};
  endfunction

  function automatic logic [30:0] exp_a(input int px, input int py);
    logic de, hs, vs;
    de = (px < 640) && (py < 480);
    hs = (px >= 656 && px < 752) ? 1'b0 : 1'b1;
    vs = (py >= 490 && py < 492) ? 1'b0 : 1'b1;
    return {12'(px), 12'(py), de, hs, vs, vs, hs, px == 0, (px == 0) && (py == 0)};
  endfunction

  function automatic logic [22:0] exp_s(input int px, input int py);
    logic de, hs, vs;
    de = (px < 16) && (py < 6);
    hs = (px >= 18 && px < 21) ? 1'b0 : 1'b1;
    vs = (py >= 7 && py < 9) ? 1'b0 : 1'b1;
    return {8'(px), 8'(py), de, hs, vs, vs, hs, px == 0, (px == 0) && (py == 0)};
  endfunction

  task automatic test_reset();
    rst_n_a = 1'b0; rst_n_s = 1'b0; ce_a = 1'b1; ce_s = 1'b1;
    tick(); tick();
    checks++;
    if (got_a() !== RST_A) begin
      failures++; $display("FAIL reset_dflt got=%h exp=%h", got_a(), RST_A);
    end
    checks++;
    if (got_s() !== RST_S) begin
      failures++; $display("FAIL reset_small got=%h exp=%h", got_s(), RST_S);
    end
    ce_a = 1'b0; ce_s = 1'b0; rst_n_a = 1'b1; rst_n_s = 1'b1;
    tick();
    checks++;
    if (got_a() !== RST_A) begin
      failures++; $display("FAIL reset_hold_ce0 got=%h exp=%h", got_a(), RST_A);
    end
  endtask

  task automatic test_hline();
    int run = 0, best_run = 0, last_ls = -1, period = 0;
    ce_a = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      tick();
      if (k == 0) begin
        checks++;
        if (!(x_a === 12'd0 && y_a === 12'd0 && de_a === 1'b1 && fs_a === 1'b1 && ls_a === 1'b1)) begin
          failures++;
          $display("FAIL first_pixel got x=%0d y=%0d de=%b fs=%b ls=%b exp x=0 y=0 de=1 fs=1 ls=1",
                   x_a, y_a, de_a, fs_a, ls_a);
        end
      end
      checks++;
      if (got_a() !== exp_a(k % 800, k / 800)) begin
        failures++; $display("FAIL hline k=%0d got=%h exp=%h", k, got_a(), exp_a(k % 800, k / 800));
      end
      if (de_a) begin run++; if (run > best_run) best_run = run; end else run = 0;
      if (ls_a) begin if (last_ls >= 0) period = k - last_ls; last_ls = k; end
    end
    ce_a = 1'b0;
    checks++;
    if (best_run !== 640) begin
      failures++; $display("FAIL de_run got=%0d exp=640", best_run);
    end
    checks++;
    if (period !== 800) begin
      failures++; $display("FAIL line_period got=%0d exp=800", period);
    end
  endtask

  task automatic test_ce_pattern();
    int last_rise = -1, period = 0;
    logic prev_ls = 1'b0;
    rst_n_a = 1'b0;
    tick();
    rst_n_a = 1'b1;
    for (int j = 0; j < 4803; j++) begin
      ce_a = (j % 3 == 0);
      tick();
      checks++;
      if (got_a() !== exp_a((j / 3) % 800, (j / 3) / 800)) begin
        failures++;
        $display("FAIL ce_pattern j=%0d got=%h exp=%h", j, got_a(), exp_a((j / 3) % 800, (j / 3) / 800));
      end
      if (ls_a && !prev_ls) begin if (last_rise >= 0) period = j - last_rise; last_rise = j; end
      prev_ls = ls_a;
    end
    ce_a = 1'b0;
    checks++;
    if (period !== 2400) begin
      failures++; $display("FAIL ce_line_period got=%0d exp=2400", period);
    end
  endtask

  task automatic test_vertical_frame();
    int vs_low = 0, last_fs = -1, period = 0;
    rst_n_s = 1'b0;
    tick();
    rst_n_s = 1'b1;
    ce_s = 1'b1;
    for (int k = 0; k < 560; k++) begin
      tick();
      checks++;
      if (got_s() !== exp_s(k % 25, (k / 25) % 11)) begin
        failures++; $display("FAIL vframe k=%0d got=%h exp=%h", k, got_s(), exp_s(k % 25, (k / 25) % 11));
      end
      if (k == 274) begin
        checks++;
        if (!(x_s === 8'd24 && y_s === 8'd10 && fs_s === 1'b0 && hs_s === 1'b1 && vs_s === 1'b1)) begin
          failures++;
          $display("FAIL wrap_last got x=%0d y=%0d fs=%b hs=%b vs=%b exp x=24 y=10 fs=0 hs=1 vs=1",
                   x_s, y_s, fs_s, hs_s, vs_s);
        end
      end
      if (k == 275) begin
        checks++;
        if (!(x_s === 8'd0 && y_s === 8'd0 && fs_s === 1'b1 && hs_s === 1'b1 && vs_s === 1'b1)) begin
          failures++;
          $display("FAIL wrap_first got x=%0d y=%0d fs=%b hs=%b vs=%b exp x=0 y=0 fs=1 hs=1 vs=1",
                   x_s, y_s, fs_s, hs_s, vs_s);
        end
      end
      if (k < 275 && !vs_s) vs_low++;
      if (fs_s) begin if (last_fs >= 0) period = k - last_fs; last_fs = k; end
    end
    ce_s = 1'b0;
    checks++;
    if (vs_low !== 50) begin
      failures++; $display("FAIL vsync_len got=%0d exp=50", vs_low);
    end
    checks++;
    if (period !== 275) begin
      failures++; $display("FAIL frame_period got=%0d exp=275", period);
    end
  endtask

  task automatic test_async_reset();
    rst_n_s = 1'b0;
    tick();
    rst_n_s = 1'b1;
    ce_s = 1'b1;
    for (int k = 0; k < 86; k++) tick();
    checks++;
    if (got_s() !== exp_s(10, 3)) begin
      failures++; $display("FAIL pre_reset_pos got=%h exp=%h", got_s(), exp_s(10, 3));
    end
    #2;
    rst_n_s = 1'b0;
    #1;
    checks++;
    if (got_s() !== RST_S) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", got_s(), RST_S);
    end
    tick();
    checks++;
    if (got_s() !== RST_S) begin
      failures++; $display("FAIL reset_held got=%h exp=%h", got_s(), RST_S);
    end
    rst_n_s = 1'b1;
    tick();
    checks++;
    if (got_s() !== exp_s(0, 0)) begin
      failures++; $display("FAIL post_reset_first got=%h exp=%h", got_s(), exp_s(0, 0));
    end
    tick();
    checks++;
    if (got_s() !== exp_s(1, 0)) begin
      failures++; $display("FAIL post_reset_second got=%h exp=%h", got_s(), exp_s(1, 0));
    end
    ce_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hline();
    test_ce_pattern();
    test_vertical_frame();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the three TMDS channel encoders.
- Produces pixel position, data-enable, and horizontal/vertical sync. Sync is also packed as the 2-bit control word the blue-channel encoder sends during blanking.
- Also provides frame and line start strokes to the pixel source.
- Runs on the pixel clock, with an optional clock-enable for divided-rate operation.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync
- CW, 12, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, asynchronous active-low reset
- ce, input, 1, pixel advance enable; tie high for one pixel per clk
- x, output, CW, horizontal position of current output pixel, 0..H_TOTAL-1
- y, output, CW, vertical position of current output pixel, 0..V_TOTAL-1
- de, output, 1, high when x<H_ACTIVE and y<V_ACTIVE
- hsync, output, 1, horizontal sync at HS_POL
- vsync, output, 1, vertical sync at VS_POL
- ctrl, output, 2, {vsync, hsync}; feeds the blue-channel encoder ctrl input
- line_start, output, 1, one-output-cycle pulse when x==0
- frame_start, output, 1, one-output-cycle pulse when x==0 and y==0

Behaviour:
- Derived values:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800 at defaults).
  - V_TOTAL is the same sum over the vertical parameters (525 at defaults).
- Internal position counters hc and vc.
- Reset (rst_n low, asynchronous):
  - hc=0, vc=0, x=0, y=0.
  - de=0, line_start=0, frame_start=0.
  - hsync=~HS_POL, vsync=~VS_POL, ctrl={~VS_POL,~HS_POL}.
  - Reset mid-frame abandons the frame with no partial outputs.
- On a clk edge with ce=1:
  - All outputs are registered from the decode of (hc,vc).
  - Then hc increments. If hc==H_TOTAL-1, hc wraps to 0 and vc increments; vc wraps to 0 after V_TOTAL-1.
  - Latency: outputs show position P one clk after the ce edge that consumed P.
  - The first ce edge after reset release outputs (0,0), with frame_start=1 and line_start=1.
- ce=0: counters and all outputs hold, including pulse outputs. Pulses are defined per ce-qualified cycle, so downstream logic samples them only with ce.
- Decode, all comparisons unsigned at CW bits:
  - de = (hc<H_ACTIVE) && (vc<V_ACTIVE).
  - hsync asserted iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for the whole line including horizontal active/blank regions; vertical sync edges align to hc==0.
- Boundary cases:
  - Simultaneous H and V wrap at (H_TOTAL-1, V_TOTAL-1): next output is (0,0) with frame_start=1.
  - No sequence of ce patterns ever produces hc>=H_TOTAL or vc>=V_TOTAL.
- Alignment requirement: de, hsync, vsync and ctrl are mutually aligned to the same pixel. Encoder latency is identical for all channels, so there is no skew compensation inside this block.

Decomposition:
- Shared package video_timing_pkg holds:
  - the default 640x480@60 parameter set, plus 800x600 and 1280x720 sets as named constants;
  - the H_TOTAL/V_TOTAL derivation;
  - the ctrl bit ordering constant (bit1=vsync, bit0=hsync).
- One natural sub-module: timing_axis_counter. It is a single wrapping counter with active/sync window decode, instantiated once for horizontal and once for vertical. The vertical instance steps on the horizontal wrap.

Test Plan:
- Reset then ce=1 continuously at defaults:
  - First output is x=0, y=0, de=1, frame_start=1.
  - The de-high run per line is exactly 640 cycles.
  - Period between line_start pulses is 800 cycles; period between frame_start pulses is 420000 cycles.
- Horizontal sync window:
  - hsync=0 exactly for x=656..751, hsync=1 elsewhere.
  - ctrl[0] tracks hsync.
  - de=0 for x>=640.
- Vertical sync window:
  - vsync=0 for all 1600 cycles with y=490..491.
  - de=0 for all y>=480.
  - ctrl[1] tracks vsync.
- ce pattern 1,0,0,1 repeated: outputs hold during ce=0. Position sequence is identical to the ce=1 run, with 3x the cycle counts: line period 2400 clk.
- Assert rst_n=0 asynchronously at x=300, y=200:
  - Outputs go to reset values without a clk edge.
  - After release, the first ce edge outputs (0,0) with frame_start=1.
- Wrap corner: observe outputs (799,524) then (0,0). frame_start rises only on the (0,0) output, and vsync/hsync are deasserted at both positions.
